mm_sequencer: RTL and testbench

- Sequencer for the matrix-multiply accelerator instruction (the custom opcode that raises operation_en in the decoder).
- On operation_en it takes ownership of the data-memory port and stalls the core.
- Computes C = A x B for fixed NxN matrices of DW-bit words stored row-major at fixed base addresses, writing each C element back to dmem.
- Sits between the control decoder, the core's PC/stall logic and the dmem port mux.

---
 rtl/mm_sequencer.sv | 146 ++++++++++++++
 tb/tb_mm_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_sequencer.sv
// Matrix-multiply sequencer: owns the dmem port while computing C = A x B (NxN, row-major).
// Optional MM_SATURATE_EN: signed operands, 2*DW accumulator, clamped write-back.
module mm_sequencer #(
    parameter int          N      = 4,
    parameter int          DW     = 32,
    parameter logic [31:0] A_BASE = 32'h0000_0100,
    parameter logic [31:0] B_BASE = 32'h0000_0200,
    parameter logic [31:0] C_BASE = 32'h0000_0300
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          operation_en,
    output logic          stall,
    output logic          mem_sel,
    output logic [31:0]   daddr,
    input  logic [DW-1:0] drdata,
    output logic [DW-1:0] dwdata,
    output logic [3:0]    dwe,
    output logic          done
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR, DONE} state_t;

    localparam logic [2:0] LAST = 3'(N - 1);

    state_t        state;
    logic [2:0]    i, j, k;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] wr_value;

`ifdef MM_SATURATE_EN
    localparam logic signed [2*DW-1:0] MAXV = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [2*DW-1:0] MINV = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [2*DW-1:0] acc, acc_next, prod;

    always_comb begin
        prod     = $signed({{DW{a_reg[DW-1]}}, a_reg}) * $signed({{DW{drdata[DW-1]}}, drdata});
        acc_next = acc + prod;
        if (acc_next > MAXV)
            wr_value = MAXV[DW-1:0];
        else if (acc_next < MINV)
            wr_value = MINV[DW-1:0];
        else
            wr_value = acc_next[DW-1:0];
    end
`else
    logic [DW-1:0] acc, acc_next;

    always_comb begin
        acc_next = acc + a_reg * drdata;
        wr_value = acc_next;
    end
`endif

    function automatic logic [31:0] elem(input logic [31:0] base, input logic [2:0] r,
                                         input logic [2:0] c);
        return base + ((32'(r) * 32'(N) + 32'(c)) << 2);
    endfunction

    // Start term is combinational so the issuing instruction is held from its first cycle.
    assign stall = (state != IDLE) || operation_en;

    // Outputs are registered: each transition loads the values the next state presents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            acc     <= '0;
            a_reg   <= '0;
            mem_sel <= 1'b0;
            daddr   <= '0;
            dwdata  <= '0;
            dwe     <= '0;
            done    <= 1'b0;
        end else begin
            dwe    <= '0;
            dwdata <= '0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (operation_en) begin
                        state   <= RD_A;
                        i       <= '0;
                        j       <= '0;
                        k       <= '0;
                        acc     <= '0;
                        mem_sel <= 1'b1;
                        daddr   <= elem(A_BASE, 3'd0, 3'd0);
                    end
                end
                RD_A: begin
                    state <= RD_B;
                    daddr <= elem(B_BASE, k, j);
                end
                RD_B: begin
                    state <= MAC;
                    a_reg <= drdata;
                end
                MAC: begin
                    acc <= acc_next;
                    if (k != LAST) begin
                        k     <= k + 3'd1;
                        state <= RD_A;
                        daddr <= elem(A_BASE, i, k + 3'd1);
                    end else begin
                        k      <= '0;
                        state  <= WR;
                        daddr  <= elem(C_BASE, i, j);
                        dwdata <= wr_value;
                        dwe    <= 4'hF;
                    end
                end
                WR: begin
                    acc <= '0;
                    if (j != LAST) begin
                        j     <= j + 3'd1;
                        state <= RD_A;
                        daddr <= elem(A_BASE, i, 3'd0);
                    end else if (i != LAST) begin
                        j     <= '0;
                        i     <= i + 3'd1;
                        state <= RD_A;
                        daddr <= elem(A_BASE, i + 3'd1, 3'd0);
                    end else begin
                        state   <= DONE;
                        done    <= 1'b1;
                        mem_sel <= 1'b0;
                        daddr   <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_sel <= 1'b0;
                    daddr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_sequencer.sv
// Directed self-checking bench for mm_sequencer: an N=2 instance and an N=4 instance,
// each with its own 1-cycle-latency word memory model.
module tb_mm_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic op2 = 1'b0, op4 = 1'b0;

    logic        stall2, mem_sel2, done2, stall4, mem_sel4, done4;
    logic [31:0] daddr2, rd2, wd2, daddr4, rd4, wd4;
    logic [3:0]  dwe2, dwe4;

    mm_sequencer #(.N(2), .DW(32), .A_BASE(32'h100), .B_BASE(32'h200), .C_BASE(32'h300)) u2 (
        .clk(clk), .reset(reset), .operation_en(op2), .stall(stall2), .mem_sel(mem_sel2),
        .daddr(daddr2), .drdata(rd2), .dwdata(wd2), .dwe(dwe2), .done(done2));

    mm_sequencer #(.N(4), .DW(32), .A_BASE(32'h100), .B_BASE(32'h200), .C_BASE(32'h300)) u4 (
        .clk(clk), .reset(reset), .operation_en(op4), .stall(stall4), .mem_sel(mem_sel4),
        .daddr(daddr4), .drdata(rd4), .dwdata(wd4), .dwe(dwe4), .done(done4));

    logic [31:0] mem2 [256];
    logic [31:0] mem4 [256];

    always @(posedge clk) begin
        rd2 <= mem2[daddr2[9:2]];
        if (dwe2 == 4'hF) mem2[daddr2[9:2]] <= wd2;
        rd4 <= mem4[daddr4[9:2]];
        if (dwe4 == 4'hF) mem4[daddr4[9:2]] <= wd4;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int s2 = 0, s4 = 0, nwr = 0, ndone = 0, ndone4 = 0, done4_rel = -1, stall_gap = 0;
    logic chk_stall = 1'b0;
    int          wcyc  [16];
    logic [31:0] waddr [16];
    logic [31:0] wdat  [16];
    int          dcyc  [4];

    always @(negedge clk) begin
        if (dwe2 != 4'h0) begin
            if (nwr < 16) begin
                wcyc[nwr]  = cyc - s2;
                waddr[nwr] = daddr2;
                wdat[nwr]  = wd2;
            end
            nwr++;
        end
        if (done2) begin
            if (ndone < 4) dcyc[ndone] = cyc - s2;
            ndone++;
        end
        if (done4) begin
            done4_rel = cyc - s4;
            ndone4++;
        end
        if (chk_stall && !stall2) stall_gap++;
    end

    int checks = 0, passes = 0, fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load2(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3);
        mem2[8'h40] = a0; mem2[8'h41] = a1; mem2[8'h42] = a2; mem2[8'h43] = a3;
        mem2[8'h80] = b0; mem2[8'h81] = b1; mem2[8'h82] = b2; mem2[8'h83] = b3;
        for (int n = 0; n < 4; n++) mem2[8'hC0 + n] = 32'hDEAD_BEEF;
    endtask

    task automatic start2();
        nwr = 0;
        ndone = 0;
        op2 = 1'b1;
        s2 = cyc;
        tick();
        op2 = 1'b0;
    endtask

    task automatic wait_done2(input string tag, input int budget);
        int n0 = ndone;
        int t = 0;
        while (ndone == n0 && t < budget) begin
            tick();
            t++;
        end
        chk(tag, 32'(ndone > n0), 32'd1);
    endtask

    logic [31:0] ra [16];
    logic [31:0] rb [16];
    logic [31:0] sum;

    initial begin
        for (int n = 0; n < 256; n++) begin
            mem2[n] = '0;
            mem4[n] = '0;
        end

        // reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_stall", 32'(stall2), 32'd0);
        chk("rst_mem_sel", 32'(mem_sel2), 32'd0);
        chk("rst_daddr", daddr2, 32'd0);
        chk("rst_dwe", 32'(dwe2), 32'd0);
        chk("rst_done", 32'(done2), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // basic 2x2 product with timing
        load2(1, 2, 3, 4, 5, 6, 7, 8);
        chk_stall = 1'b1;
        stall_gap = 0;
        start2();
        wait_done2("t1_timeout", 60);
        chk_stall = 1'b0;
        @(negedge clk);
        chk("t1_stall_after", 32'(stall2), 32'd0);
        chk("t1_stall_gap", 32'(stall_gap), 32'd0);
        chk("t1_nwr", 32'(nwr), 32'd4);
        chk("t1_done_cyc", 32'(dcyc[0]), 32'd29);
        chk("t1_ndone", 32'(ndone), 32'd1);
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("t1_wcyc%0d", n), 32'(wcyc[n]), 32'(7 * (n + 1)));
            chk($sformatf("t1_waddr%0d", n), waddr[n], 32'h300 + 32'(4 * n));
        end
        chk("t1_c00", wdat[0], 32'd19);
        chk("t1_c01", wdat[1], 32'd22);
        chk("t1_c10", wdat[2], 32'd43);
        chk("t1_c11", wdat[3], 32'd50);
        tick();

        // identity x B
        load2(1, 0, 0, 1, 9, 8, 7, 6);
        start2();
        wait_done2("t2_timeout", 60);
        chk("t2_nwr", 32'(nwr), 32'd4);
        chk("t2_c00", mem2[8'hC0], 32'd9);
        chk("t2_c01", mem2[8'hC1], 32'd8);
        chk("t2_c10", mem2[8'hC2], 32'd7);
        chk("t2_c11", mem2[8'hC3], 32'd6);
        chk("t2_a01", mem2[8'h41], 32'd0);
        chk("t2_a11", mem2[8'h43], 32'd1);
        chk("t2_b00", mem2[8'h80], 32'd9);
        chk("t2_b11", mem2[8'h83], 32'd6);
        tick();

        // accumulator overflow: wrap to 0, or clamp when saturating
        load2(32'h1_0000, 32'h1_0000, 32'h1_0000, 32'h1_0000,
              32'h1_0000, 32'h1_0000, 32'h1_0000, 32'h1_0000);
        start2();
        wait_done2("t3_timeout", 60);
        for (int n = 0; n < 4; n++)
`ifdef MM_SATURATE_EN
            chk($sformatf("t3_c%0d", n), mem2[8'hC0 + n], 32'h7FFF_FFFF);
`else
            chk($sformatf("t3_c%0d", n), mem2[8'hC0 + n], 32'h0);
`endif
        tick();

        // reset in cycle 10, after the first write-back
        load2(1, 2, 3, 4, 5, 6, 7, 8);
        start2();
        repeat (9) tick();
        chk("t4_cycle", 32'(cyc - s2), 32'd10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t4_stall", 32'(stall2), 32'd0);
        chk("t4_mem_sel", 32'(mem_sel2), 32'd0);
        chk("t4_dwe", 32'(dwe2), 32'd0);
        chk("t4_daddr", daddr2, 32'd0);
        repeat (40) tick();
        chk("t4_ndone", 32'(ndone), 32'd0);
        chk("t4_nwr", 32'(nwr), 32'd1);
        chk("t4_c00", mem2[8'hC0], 32'd19);
        chk("t4_c01", mem2[8'hC1], 32'hDEAD_BEEF);
        start2();
        wait_done2("t4_rerun_timeout", 60);
        chk("t4_rerun_done", 32'(dcyc[0]), 32'd29);
        chk("t4_rerun_c11", mem2[8'hC3], 32'd50);
        tick();

        // operation_en held high for 40 cycles
        nwr = 0;
        ndone = 0;
        op2 = 1'b1;
        s2 = cyc;
        repeat (40) tick();
        op2 = 1'b0;
        wait_done2("t5_timeout", 60);
        chk("t5_ndone", 32'(ndone), 32'd2);
        chk("t5_done0", 32'(dcyc[0]), 32'd29);
        chk("t5_done1", 32'(dcyc[1]), 32'd59);
        chk("t5_nwr", 32'(nwr), 32'd8);
        chk("t5_wcyc4", 32'(wcyc[4]), 32'd37);
        tick();

        // N=4 random vs reference model
        for (int n = 0; n < 16; n++) begin
`ifdef MM_SATURATE_EN
            ra[n] = $urandom_range(0, 1000);
            rb[n] = $urandom_range(0, 1000);
`else
            ra[n] = $urandom;
            rb[n] = $urandom;
`endif
            mem4[8'h40 + n] = ra[n];
            mem4[8'h80 + n] = rb[n];
            mem4[8'hC0 + n] = 32'hDEAD_BEEF;
        end
        op4 = 1'b1;
        s4 = cyc;
        tick();
        op4 = 1'b0;
        for (int t = 0; t < 400 && ndone4 == 0; t++) tick();
        chk("t6_ndone", 32'(ndone4), 32'd1);
        chk("t6_done_cyc", 32'(done4_rel), 32'd209);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sum = '0;
                for (int q = 0; q < 4; q++) sum = sum + ra[r * 4 + q] * rb[q * 4 + c];
                chk($sformatf("t6_c%0d%0d", r, c), mem4[8'hC0 + r * 4 + c], sum);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
